// File: rtl/tmr_pkg.sv
// Shared types and lane indices for the TMR voting controller.
package tmr_pkg;

  localparam int NUM_LANES = 3;
  localparam int LANE_A    = 0;
  localparam int LANE_B    = 1;
  localparam int LANE_C    = 2;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    VOTE,
    OUT
  } state_t;

endpackage

// File: rtl/tmr_vote_ctrl_if.sv
// Lane-capture and voted-output handshake bundle for tmr_vote_ctrl.
interface tmr_vote_ctrl_if #(
  parameter int W = 8
);
  logic [2:0]   in_valid;
  logic [W-1:0] in_data_a;
  logic [W-1:0] in_data_b;
  logic [W-1:0] in_data_c;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_uncorr;
  logic [2:0]   mismatch;
  logic [2:0]   lane_fault;
  logic         fault_clr;

  modport slave (
    input  in_valid, in_data_a, in_data_b, in_data_c, out_ready, fault_clr,
    output in_ready, out_valid, out_data, out_uncorr, mismatch, lane_fault
  );

  modport master (
    output in_valid, in_data_a, in_data_b, in_data_c, out_ready, fault_clr,
    input  in_ready, out_valid, out_data, out_uncorr, mismatch, lane_fault
  );
endinterface

// File: rtl/maj3_word.sv
// Bitwise 3-input majority over a W-bit word.
module maj3_word #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y
);
  assign y = (a & b) | (b & c) | (c & a);
endmodule

// File: rtl/tmr_vote_ctrl.sv
// TMR sequencing controller: gathers three lane words (with timeout), votes,
// presents the result on valid/ready and retires persistently failing lanes.
module tmr_vote_ctrl
  import tmr_pkg::*;
#(
  parameter int W          = 8,
  parameter int TIMEOUT    = 15,
  parameter int TW         = 4,
  parameter int ERR_THRESH = 3,
  parameter int EW         = 3
) (
  input logic            clk,
  input logic            rst,
  tmr_vote_ctrl_if.slave bus
);

  state_t               state, state_nxt;
  logic [TW-1:0]        timer;
  logic [NUM_LANES-1:0] cap, cap_all, take, req_q, req_now, present;
  logic [NUM_LANES-1:0] lane_fault_q, fault_nxt, vote_mm, mismatch_q;
  logic [W-1:0]         lane_in  [NUM_LANES];
  logic [W-1:0]         word_q   [NUM_LANES];
  logic [EW-1:0]        err_cnt  [NUM_LANES];
  logic [EW-1:0]        err_nxt  [NUM_LANES];
  logic [W-1:0]         maj_word, vote_data, out_data_q;
  logic                 vote_uncorr, out_uncorr_q;
  logic                 in_ready_c, done, timeout_hit;

  assign lane_in[LANE_A] = bus.in_data_a;
  assign lane_in[LANE_B] = bus.in_data_b;
  assign lane_in[LANE_C] = bus.in_data_c;

  assign in_ready_c     = (state == IDLE) || (state == COLLECT);
  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = (state == OUT);
  assign bus.out_data   = out_data_q;
  assign bus.out_uncorr = out_uncorr_q;
  assign bus.mismatch   = mismatch_q;
  assign bus.lane_fault = lane_fault_q;

  // The required set is frozen at transaction start so a mid-transaction
  // fault_clr only affects the next transaction.
  assign req_now     = (state == IDLE) ? ~lane_fault_q : req_q;
  assign take        = bus.in_valid & req_now & ~cap & {NUM_LANES{in_ready_c}};
  assign cap_all     = cap | take;
  assign done        = (cap_all & req_now) == req_now;
  assign timeout_hit = timer == TW'(TIMEOUT - 1);
  assign present     = cap & req_q;

  maj3_word #(.W(W)) u_maj (
    .a (word_q[LANE_A]),
    .b (word_q[LANE_B]),
    .c (word_q[LANE_C]),
    .y (maj_word)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (done) state_nxt = VOTE;
               else if (|take) state_nxt = COLLECT;
      COLLECT: if (done || timeout_hit) state_nxt = VOTE;
      VOTE:    state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and infers a latch.
  always_comb begin
    vote_data   = '0;
    vote_uncorr = 1'b1;
    case (present)
      3'b111: begin vote_data = maj_word; vote_uncorr = 1'b0; end
      3'b011: begin
        vote_data   = word_q[LANE_A];
        vote_uncorr = word_q[LANE_A] != word_q[LANE_B];
      end
      3'b101: begin
        vote_data   = word_q[LANE_A];
        vote_uncorr = word_q[LANE_A] != word_q[LANE_C];
      end
      3'b110: begin
        vote_data   = word_q[LANE_B];
        vote_uncorr = word_q[LANE_B] != word_q[LANE_C];
      end
      3'b001:  vote_data = word_q[LANE_A];
      3'b010:  vote_data = word_q[LANE_B];
      3'b100:  vote_data = word_q[LANE_C];
      default: vote_data = '0;
    endcase

    // A required lane missing at vote time can only mean it timed out.
    for (int i = 0; i < NUM_LANES; i++) begin
      vote_mm[i]   = req_q[i] & (~cap[i] | (word_q[i] != vote_data));
      err_nxt[i]   = err_cnt[i];
      fault_nxt[i] = lane_fault_q[i];
      if (req_q[i]) begin
        if (!vote_mm[i])                           err_nxt[i] = '0;
        else if (err_cnt[i] != EW'(ERR_THRESH))    err_nxt[i] = err_cnt[i] + EW'(1);
        if (err_nxt[i] == EW'(ERR_THRESH))         fault_nxt[i] = 1'b1;
      end
    end
  end

  // NOTE: lane word registers carry no reset; they are only read behind
  // their capture flag, which is reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++)
      if (take[i]) word_q[i] <= lane_in[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer        <= '0;
      cap          <= '0;
      req_q        <= '0;
      out_data_q   <= '0;
      out_uncorr_q <= 1'b0;
      mismatch_q   <= '0;
      lane_fault_q <= '0;
      for (int i = 0; i < NUM_LANES; i++) err_cnt[i] <= '0;
    end else begin
      cap   <= (state == OUT) ? '0 : cap_all;
      timer <= (state == COLLECT) ? timer + TW'(1) : '0;
      if (state == IDLE) req_q <= ~lane_fault_q;
      if (state == VOTE) begin
        out_data_q   <= vote_data;
        out_uncorr_q <= vote_uncorr;
        mismatch_q   <= vote_mm;
        lane_fault_q <= fault_nxt;
        for (int i = 0; i < NUM_LANES; i++) err_cnt[i] <= err_nxt[i];
      end
      if (bus.fault_clr) begin
        lane_fault_q <= '0;
        for (int i = 0; i < NUM_LANES; i++) err_cnt[i] <= '0;
      end
    end
  end

endmodule
